shift_seq8: RTL and testbench

Multi-cycle 8-bit shift sequencer that sits in front of the 2-bit-amount 4:1-mux shifter stage. It accepts shift amounts of 0–7 and breaks each one into steps of at most 3, applying one step per clock through its internal shifter datapath. It supports logical right, logical left, arithmetic right and rotate right. The result is registered and flagged with a one-cycle `done` pulse.

---
 rtl/shift_seq8.sv | 119 +++++++++++
 tb/tb_shift_seq8.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer: splits a 0-7 shift into steps of at most 3,
// applying one step per clock; supports LSR, LSL, ASR and ROR.
module shift_seq8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] amount,
    input  logic [7:0] d_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_out
);

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] data_reg, data_next;
    logic [2:0] rem_reg, rem_next;
    logic [1:0] op_reg, op_next;
    logic [7:0] d_out_reg, d_out_next;

    logic [1:0] step;
    logic [2:0] rem_after;
    logic [7:0] shifted;

    // One step of the 2-bit-amount shifter; right-going ops share a 16-bit window
    // whose upper half supplies the fill bits.
    function automatic logic [7:0] shift_step(input logic [7:0] v,
                                              input logic [1:0] o,
                                              input logic [1:0] s);
        logic [15:0] win;
        logic [15:0] win_sh;
        logic [7:0]  res;
        win = {8'h00, v};
        case (o)
            OP_ASR:  win = {{8{v[7]}}, v};
            OP_ROR:  win = {v, v};
            default: win = {8'h00, v};
        endcase
        win_sh = win >> s;
        res    = win_sh[7:0];
        if (o == OP_LSL)
            res = v << s;
        return res;
    endfunction

    assign step      = (rem_reg > 3'd3) ? 2'd3 : rem_reg[1:0];
    assign rem_after = rem_reg - {1'b0, step};
    assign shifted   = shift_step(data_reg, op_reg, step);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            data_reg  <= 8'h00;
            rem_reg   <= 3'd0;
            op_reg    <= 2'd0;
            d_out_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rem_reg   <= rem_next;
            op_reg    <= op_next;
            d_out_reg <= d_out_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rem_next   = rem_reg;
        op_next    = op_reg;
        d_out_next = d_out_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    data_next = d_in;
                    op_next   = op;
                    rem_next  = amount;
                    if (amount == 3'd0) begin
                        // Zero-distance request publishes the operand unchanged.
                        d_out_next = d_in;
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_next = shifted;
                rem_next  = rem_after;
                if (rem_after == 3'd0) begin
                    d_out_next = shifted;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);
    assign d_out = d_out_reg;

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: vector table driven through a scoreboard,
// plus hand sequences for async reset, busy-drop and reset mid-operation.
module tb_shift_seq8;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] amount;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int n_vec = 0;
    int n_err = 0;

    shift_seq8 dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .amount (amount),
        .d_in   (d_in),
        .busy   (busy),
        .done   (done),
        .d_out  (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [2:0] amount;
        logic [7:0] d_in;
        logic [7:0] exp_out;
    } vec_t;

    typedef struct {
        logic [7:0] exp_out;
        int         exp_lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one operation at a negedge, then follow it until done. With inject=1 a
    // conflicting start is pulsed while busy, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] exp_out, input bit inject);
        sb_t exp;
        int  lat;
        int  busy_cnt;
        int  done_cnt;
        exp.exp_out = exp_out;
        exp.exp_lat = (int'(a) + 2) / 3 + 1;
        sb_q.push_back(exp);
        op = o; amount = a; d_in = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; busy_cnt = 0; done_cnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (inject && lat == 1) begin
                start = 1'b1; op = ~o; amount = 3'd0; d_in = ~d;
            end else if (inject && lat == 2) begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout: op=%0d amt=%0d no done within 20 cycles", o, a);
            void'(sb_q.pop_front());
            return;
        end
        exp = sb_q.pop_front();
        done_cnt = 1;
        check("d_out", {24'd0, d_out}, {24'd0, exp.exp_out});
        check("latency", lat, exp.exp_lat);
        check("busy_cycles", busy_cnt, exp.exp_lat);
        $display("op=%0d amt=%0d d_in=%02h -> d_out=%02h lat=%0d", o, a, d, d_out, lat);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("d_out_hold", {24'd0, d_out}, {24'd0, exp.exp_out});
        if (inject) begin
            repeat (4) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            check("single_done", done_cnt, 1);
            check("d_out_kept", {24'd0, d_out}, {24'd0, exp.exp_out});
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 3'd5, 8'hB4, 8'h05};
        vecs[1]  = '{2'b01, 3'd7, 8'h81, 8'h80};
        vecs[2]  = '{2'b11, 3'd7, 8'h01, 8'h02};
        vecs[3]  = '{2'b10, 3'd4, 8'h90, 8'hF9};
        vecs[4]  = '{2'b00, 3'd0, 8'h3C, 8'h3C};
        vecs[5]  = '{2'b10, 3'd3, 8'h7F, 8'h0F};
        vecs[6]  = '{2'b11, 3'd3, 8'hA5, 8'hB4};
        vecs[7]  = '{2'b01, 3'd6, 8'h0F, 8'hC0};
        vecs[8]  = '{2'b10, 3'd7, 8'h80, 8'hFF};
        vecs[9]  = '{2'b00, 3'd1, 8'hFF, 8'h7F};
        vecs[10] = '{2'b11, 3'd4, 8'h96, 8'h69};
        vecs[11] = '{2'b01, 3'd2, 8'h55, 8'h54};

        reset_n = 1'b0; start = 1'b0; op = 2'b00; amount = 3'd0; d_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_d_out", {24'd0, d_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].amount, vecs[i].d_in, vecs[i].exp_out, 1'b0);

        // Busy-drop: conflicting request during SHIFT is discarded.
        run_op(2'b01, 3'd7, 8'h81, 8'h80, 1'b1);

        // Async reset mid-cycle with nonzero d_out, no clock edge in between.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_d_out", {24'd0, d_out}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset during the second SHIFT cycle: no done, result discarded.
        run_op(2'b00, 3'd3, 8'hF0, 8'h1E, 1'b0);
        op = 2'b00; amount = 3'd7; d_in = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midop_busy", {31'd0, busy}, 32'd0);
        check("midop_done", {31'd0, done}, 32'd0);
        check("midop_d_out", {24'd0, d_out}, 32'd0);
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) seen++;
            end
            reset_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("midop_no_done", seen, 0);
            check("midop_d_out_after", {24'd0, d_out}, 32'd0);
        end
        run_op(2'b10, 3'd5, 8'hC3, 8'hFE, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
